// File: rtl/shift_seq_ctrl_if.sv
// Request channel into the shift sequencer: load data and shift count.
// Single valid/ready handshake; a word transfers on a clock edge where valid && ready.
// The requester holds valid, data and length stable until ready is seen.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [CNT_W-1:0] req_len;

  modport master (output req_valid, output req_data, output req_len, input req_ready);
  modport slave  (input req_valid, input req_data, input req_len, output req_ready);
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving a parallel-load/shift register: one load pulse, then len shift enables.
// Latency: accept at T, load at T+1, done at T+2+len, ready again at T+3+len+GAP_CYCLES.
// Backpressure: req_ready only in IDLE (and never during reset); abort cancels LOAD/SHIFT.
module shift_seq_ctrl #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  shift_seq_ctrl_if.slave  req,
  input  logic             abort,
  output logic             sr_load,
  output logic             sr_shift_en,
  output logic [WIDTH-1:0] sr_data,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [15:0]      xfer_cnt
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(WIDTH);
  // Gap counter preloads with the last index so GAP lasts exactly GAP_CYCLES cycles.
  localparam logic [7:0]       GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_data_q, sr_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gap_q, gap_d;
  logic [15:0]      xfer_q, xfer_d;
  logic             aborted_q, aborted_d;
  logic             req_ready;

  // Moore outputs decoded from the registered state; ready is forced low while in reset.
  always_comb begin
    req_ready   = (state_q == S_IDLE) && reset_n;
    sr_load     = (state_q == S_LOAD);
    sr_shift_en = (state_q == S_SHIFT);
    done        = (state_q == S_DONE);
    busy        = (state_q != S_IDLE);
  end

  assign req.req_ready = req_ready;
  assign sr_data       = sr_data_q;
  assign aborted       = aborted_q;
  assign xfer_cnt      = xfer_q;

  // Next-state logic: capture on accept, count shifts down, count completions, time the gap.
  always_comb begin
    state_d   = state_q;
    sr_data_d = sr_data_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    xfer_d    = xfer_q;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req.req_valid && req_ready) begin
          sr_data_d = req.req_data;
          cnt_d     = (req.req_len > LEN_MAX) ? LEN_MAX : req.req_len;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        xfer_d = xfer_q + 16'd1;
        gap_d  = GAP_LAST;
        if (GAP_CYCLES > 0) begin
          state_d = S_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset discards any transfer silently.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      sr_data_q <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      xfer_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_data_q <= sr_data_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      xfer_q    <= xfer_d;
      aborted_q <= aborted_d;
    end
  end
endmodule
